// File: rtl/dp_sram_lp.sv
// Single-clock true dual-port SRAM model with per-bit write masks, same-address collision
// resolution, optional output register and a light-sleep/wake sequencer gating request acceptance.
module dp_sram_lp #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned OUT_REG     = 0,
  parameter int unsigned WAKE_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ls_i,
  output logic              ready_o,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  input  logic [DATA_W-1:0] a_bmask_i,
  output logic [DATA_W-1:0] a_rdata_o,
  output logic              a_rvalid_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  input  logic [DATA_W-1:0] b_bmask_i,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              b_rvalid_o,
  output logic              collision_o
);

  localparam int unsigned CNT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WakeInit = CNT_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StActive, StSleep, StWake} state_e;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_a_acc, w_b_acc, w_a_in, w_b_in;
  logic              w_a_wr, w_b_wr, w_a_rd, w_b_rd;
  logic              w_same, w_ww, w_coll;
  logic [DATA_W-1:0] w_a_rword, w_b_rword, w_a_new, w_b_new, w_a_keep;

  logic              r_a_v1, r_b_v1, r_coll;
  logic [DATA_W-1:0] r_a_d1, r_b_d1;

  assign ready_o = (r_state == StActive);

  // Reset also blocks acceptance so nothing is written while rst_ni is low.
  assign w_a_acc = a_req_i & ready_o & rst_ni;
  assign w_b_acc = b_req_i & ready_o & rst_ni;
  assign w_a_in  = (32'(a_addr_i) < DEPTH);
  assign w_b_in  = (32'(b_addr_i) < DEPTH);
  assign w_a_wr  = w_a_acc & a_we_i & w_a_in;
  assign w_b_wr  = w_b_acc & b_we_i & w_b_in;
  assign w_a_rd  = w_a_acc & ~a_we_i;
  assign w_b_rd  = w_b_acc & ~b_we_i;

  assign w_same  = w_a_acc & w_b_acc & w_a_in & w_b_in & (a_addr_i == b_addr_i);
  assign w_ww    = w_same & a_we_i & b_we_i;
  assign w_coll  = w_same & (a_we_i | b_we_i);

  assign w_a_rword = w_a_in ? r_mem[a_addr_i] : '0;
  assign w_b_rword = w_b_in ? r_mem[b_addr_i] : '0;

  // On a write/write hit port A commits the merged word; port A wins overlapping mask bits.
  assign w_a_keep = ~(a_bmask_i | (w_ww ? b_bmask_i : '0));
  assign w_a_new  = (w_a_rword & w_a_keep) | (a_wdata_i & a_bmask_i) |
                    (w_ww ? (b_wdata_i & b_bmask_i & ~a_bmask_i) : '0);
  assign w_b_new  = (w_b_rword & ~b_bmask_i) | (b_wdata_i & b_bmask_i);

  always_ff @(posedge clk_i) begin
    if (w_a_wr) r_mem[a_addr_i] <= w_a_new;
    if (w_b_wr && !w_ww) r_mem[b_addr_i] <= w_b_new;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_a_v1 <= 1'b0;
      r_b_v1 <= 1'b0;
      r_a_d1 <= '0;
      r_b_d1 <= '0;
      r_coll <= 1'b0;
    end else begin
      r_a_v1 <= w_a_rd;
      r_b_v1 <= w_b_rd;
      if (w_a_rd) r_a_d1 <= w_a_rword;
      if (w_b_rd) r_b_d1 <= w_b_rword;
      r_coll <= w_coll;
    end
  end

  assign collision_o = r_coll;

  if (OUT_REG != 0) begin : g_oreg
    logic              r_a_v2, r_b_v2;
    logic [DATA_W-1:0] r_a_d2, r_b_d2;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_a_v2 <= 1'b0;
        r_b_v2 <= 1'b0;
        r_a_d2 <= '0;
        r_b_d2 <= '0;
      end else begin
        r_a_v2 <= r_a_v1;
        r_b_v2 <= r_b_v1;
        if (r_a_v1) r_a_d2 <= r_a_d1;
        if (r_b_v1) r_b_d2 <= r_b_d1;
      end
    end

    assign a_rvalid_o = r_a_v2;
    assign b_rvalid_o = r_b_v2;
    assign a_rdata_o  = r_a_d2;
    assign b_rdata_o  = r_b_d2;
  end else begin : g_noreg
    assign a_rvalid_o = r_a_v1;
    assign b_rvalid_o = r_b_v1;
    assign a_rdata_o  = r_a_d1;
    assign b_rdata_o  = r_b_d1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= StActive;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StActive: begin
        if (ls_i && !a_req_i && !b_req_i) w_state_d = StSleep;
      end
      StSleep: begin
        if (!ls_i) begin
          if (WAKE_CYCLES == 0) begin
            w_state_d = StActive;
          end else begin
            w_state_d = StWake;
            w_cnt_d   = WakeInit;
          end
        end
      end
      StWake: begin
        if (ls_i) begin
          w_state_d = StSleep;
          w_cnt_d   = '0;
        end else if (r_cnt == '0) begin
          w_state_d = StActive;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      default: w_state_d = StActive;
    endcase
  end

endmodule

// File: tb/tb_dp_sram_lp.sv
// Scoreboard bench for dp_sram_lp: two instances (latency 1 and 2, DEPTH=100) share stimulus;
// expected reads are queued at issue time and matched against rvalid outputs.
module tb_dp_sram_lp;

  logic        clk = 1'b0;
  logic        rst_n, ls;
  logic        a_req, a_we, b_req, b_we;
  logic [6:0]  a_addr, b_addr;
  logic [31:0] a_wdata, a_bmask, b_wdata, b_bmask;

  logic        d0_ready, d0_a_rvalid, d0_b_rvalid, d0_coll;
  logic        d1_ready, d1_a_rvalid, d1_b_rvalid, d1_coll;
  logic [31:0] d0_a_rdata, d0_b_rdata, d1_a_rdata, d1_b_rdata;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_m [128];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  logic [3:0]  w_rv;
  logic [31:0] w_rd [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dp_sram_lp #(.DATA_W(32), .DEPTH(100), .OUT_REG(0), .WAKE_CYCLES(4)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .ls_i(ls), .ready_o(d0_ready),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_bmask_i(a_bmask), .a_rdata_o(d0_a_rdata), .a_rvalid_o(d0_a_rvalid),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_bmask_i(b_bmask), .b_rdata_o(d0_b_rdata), .b_rvalid_o(d0_b_rvalid),
    .collision_o(d0_coll)
  );

  dp_sram_lp #(.DATA_W(32), .DEPTH(100), .OUT_REG(1), .WAKE_CYCLES(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .ls_i(ls), .ready_o(d1_ready),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_bmask_i(a_bmask), .a_rdata_o(d1_a_rdata), .a_rvalid_o(d1_a_rvalid),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_bmask_i(b_bmask), .b_rdata_o(d1_b_rdata), .b_rvalid_o(d1_b_rvalid),
    .collision_o(d1_coll)
  );

  assign w_rv  = {d1_b_rvalid, d1_a_rvalid, d0_b_rvalid, d0_a_rvalid};
  assign w_rd[0] = d0_a_rdata;
  assign w_rd[1] = d0_b_rdata;
  assign w_rd[2] = d1_a_rdata;
  assign w_rd[3] = d1_b_rdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Ports 0/1 are instance 0 (latency 1), ports 2/3 are instance 1 (latency 2).
  task automatic push_rd(input int port, input logic [6:0] addr);
    exp_t e;
    e.port = port;
    e.data = (addr < 7'd100) ? mem_m[addr] : 32'h0;
    e.due  = cyc + ((port >= 2) ? 2 : 1);
    q.push_back(e);
  endtask

  // acc[i]: instance i is expected to accept and return data for reads in this request.
  task automatic issue(input logic [1:0] acc,
                       input bit ar, input bit aw, input logic [6:0] aa,
                       input logic [31:0] ad, input logic [31:0] am,
                       input bit br, input bit bw, input logic [6:0] ba,
                       input logic [31:0] bd, input logic [31:0] bm);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad; a_bmask = am;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_bmask = bm;
    if (ar && !aw && acc[0]) push_rd(0, aa);
    if (br && !bw && acc[0]) push_rd(1, ba);
    if (ar && !aw && acc[1]) push_rd(2, aa);
    if (br && !bw && acc[1]) push_rd(3, ba);
    if (acc != 2'b00) begin
      if (br && bw && ba < 7'd100) mem_m[ba] = (mem_m[ba] & ~bm) | (bd & bm);
      if (ar && aw && aa < 7'd100) mem_m[aa] = (mem_m[aa] & ~am) | (ad & am);
    end
    step(1);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready"}, {d1_ready, d0_ready}, 32'h3);
    check_eq({tag, "_rvalid"}, 32'(w_rv), 32'h0);
    check_eq({tag, "_rdata0"}, d0_a_rdata | d0_b_rdata, 32'h0);
    check_eq({tag, "_rdata1"}, d1_a_rdata | d1_b_rdata, 32'h0);
    check_eq({tag, "_coll"}, {d1_coll, d0_coll}, 32'h0);
  endtask

  task automatic check_ready(input string tag, input logic exp);
    check_eq({tag, "_d0"}, 32'(d0_ready), 32'(exp));
    check_eq({tag, "_d1"}, 32'(d1_ready), 32'(exp));
  endtask

  always @(negedge clk) begin : mon
    int idx;
    for (int p = 0; p < 4; p++) begin
      if (w_rv[p]) begin
        idx = -1;
        for (int i = 0; i < q.size(); i++) if (idx < 0 && q[i].port == p) idx = i;
        if (idx < 0) begin
          check_eq($sformatf("spurious_rvalid_p%0d", p), 32'(w_rv[p]), 32'h0);
        end else begin
          check_eq($sformatf("rdata_p%0d", p), w_rd[p], q[idx].data);
          check_eq($sformatf("latency_p%0d", p), cyc, q[idx].due);
          q.delete(idx);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 128; i++) mem_m[i] = 32'h0;
    rst_n = 1'b0; ls = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_bmask = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_bmask = '0;
    step(3);
    check_idle("reset");
    rst_n = 1'b1;

    // Basic write then read, both latencies.
    issue(2'b11, 1, 1, 7'd5, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 0, 7'd0, 32'h0, 32'h0);
    issue(2'b11, 1, 0, 7'd5, 32'h0, 32'h0, 0, 0, 7'd0, 32'h0, 32'h0);
    step(3);

    // Masked write through port B.
    issue(2'b11, 1, 1, 7'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 7'd0, 32'h0, 32'h0);
    issue(2'b11, 0, 0, 7'd0, 32'h0, 32'h0, 1, 1, 7'd7, 32'h00000000, 32'h0000FF00);
    issue(2'b11, 0, 0, 7'd0, 32'h0, 32'h0, 1, 0, 7'd7, 32'h0, 32'h0);
    step(3);

    // Write/write collision.
    issue(2'b11, 1, 1, 7'd9, 32'h11111111, 32'hFFFF0000, 1, 1, 7'd9, 32'h22222222, 32'hFFFFFFFF);
    check_eq("ww_coll", {d1_coll, d0_coll}, 32'h3);
    step(1);
    check_eq("ww_coll_pulse", {d1_coll, d0_coll}, 32'h0);
    issue(2'b11, 1, 0, 7'd9, 32'h0, 32'h0, 0, 0, 7'd0, 32'h0, 32'h0);
    step(3);

    // Read/write collision, then read/read (no flag).
    issue(2'b11, 1, 1, 7'd3, 32'hA5A5A5A5, 32'hFFFFFFFF, 0, 0, 7'd0, 32'h0, 32'h0);
    issue(2'b11, 1, 0, 7'd3, 32'h0, 32'h0, 1, 1, 7'd3, 32'h5A5A5A5A, 32'hFFFFFFFF);
    check_eq("rw_coll", {d1_coll, d0_coll}, 32'h3);
    issue(2'b11, 1, 0, 7'd3, 32'h0, 32'h0, 1, 0, 7'd3, 32'h0, 32'h0);
    check_eq("rr_no_coll", {d1_coll, d0_coll}, 32'h0);
    step(3);

    // Out-of-range accesses.
    issue(2'b11, 1, 0, 7'd100, 32'h0, 32'h0, 1, 1, 7'd120, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(2'b11, 1, 0, 7'd120, 32'h0, 32'h0, 1, 0, 7'd9, 32'h0, 32'h0);
    step(3);

    // Sleep request with a pending request keeps the array active.
    ls = 1'b1;
    issue(2'b11, 1, 0, 7'd7, 32'h0, 32'h0, 0, 0, 7'd0, 32'h0, 32'h0);
    ls = 1'b0;
    check_ready("ls_with_req", 1'b1);
    step(3);

    // Idle sleep: requests ignored, then exactly four wake cycles.
    ls = 1'b1;
    step(1);
    check_ready("sleep", 1'b0);
    issue(2'b00, 1, 0, 7'd5, 32'h0, 32'h0, 1, 1, 7'd5, 32'h0, 32'hFFFFFFFF);
    step(2);
    ls = 1'b0;
    step(1);
    for (int i = 0; i < 5; i++) begin
      check_ready($sformatf("wake_%0d", i), (i == 4));
      if (i < 4) step(1);
    end
    issue(2'b11, 1, 0, 7'd5, 32'h0, 32'h0, 0, 0, 7'd0, 32'h0, 32'h0);
    step(3);

    // Re-sleep during WAKE, then a full wake.
    ls = 1'b1;
    step(1);
    ls = 1'b0;
    step(2);
    ls = 1'b1;
    step(1);
    check_ready("resleep", 1'b0);
    step(1);
    check_ready("resleep_hold", 1'b0);
    ls = 1'b0;
    n = 0;
    while (!(d0_ready && d1_ready) && n < 20) begin
      step(1);
      n++;
    end
    check_eq("rewake_ready", {d1_ready, d0_ready}, 32'h3);
    check_eq("rewake_len", n, 32'd5);

    // Reset one cycle after an accepted read: latency-2 instance must drop it.
    issue(2'b01, 1, 0, 7'd3, 32'h0, 32'h0, 0, 0, 7'd0, 32'h0, 32'h0);
    rst_n = 1'b0;
    step(1);
    check_idle("midreset");
    rst_n = 1'b1;
    step(4);

    check_eq("outstanding", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
